// File: rtl/adder_pkg.sv
// Shared definitions for the Sklansky adder: the default width and the
// generate/propagate pair carried between prefix levels.
package adder_pkg;

    localparam int ADDER_WIDTH  = 32;
    localparam int ADDER_LEVELS = 5;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

endpackage

// File: rtl/sklansky_adder_32_if.sv
// Operand/result bundle for the registered adder. There is no valid/ready:
// a new (a, b, cin) set is captured on every rising edge and its result is
// on sum/cout for the whole following cycle.
interface sklansky_adder_32_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);

endinterface

// File: rtl/sklansky_pg_cell.sv
// Prefix black cell: merges a higher (gh, ph) group with the adjacent lower
// (gl, pl) group into the generate/propagate of their union.
module sklansky_pg_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/sklansky_adder_32.sv
// Registered parallel-prefix adder: a + b + cin through a Sklansky carry
// network of log2(WIDTH) levels, with sum and carry-out held in one register.
module sklansky_adder_32
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH  // power of two, at least 2
) (
    input  logic               clk,
    input  logic               rst,
    sklansky_adder_32_if.slave bus
);

    localparam int LEVELS = $clog2(WIDTH);

    // node[k][i] is the (G, P) of bit i after k levels; node[0] is bit-level.
    pg_t              node [0:LEVELS][0:WIDTH-1];
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign node[0][i] = '{g: bus.a[i] & bus.b[i], p: bus.a[i] ^ bus.b[i]};
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i >> k) & 1) == 1) begin : g_black
                // Top bit of the lower half of this 2^(k+1)-wide block.
                localparam int J = ((i >> (k + 1)) << (k + 1)) + (1 << k) - 1;
                logic g_o;
                logic p_o;
                sklansky_pg_cell u_cell (
                    .gh(node[k][i].g),
                    .ph(node[k][i].p),
                    .gl(node[k][J].g),
                    .pl(node[k][J].p),
                    .g (g_o),
                    .p (p_o)
                );
                assign node[k+1][i] = '{g: g_o, p: p_o};
            end else begin : g_pass
                assign node[k+1][i] = node[k][i];
            end
        end
    end

    // cin is folded in after the network rather than entering as a node.
    assign c[0] = bus.cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_sum
        assign c[i+1]   = node[LEVELS][i].g | (node[LEVELS][i].p & bus.cin);
        assign sum_d[i] = node[0][i].p ^ c[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= sum_d;
            bus.cout <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_sklansky_adder_32.sv
// Bench for sklansky_adder_32: directed corner operands, a random stream with
// a mid-stream reset pulse, and a queue of expected 33-bit sums.
module tb_sklansky_adder_32;

    localparam int W = 32;

    logic clk;
    logic rst;
    logic drv_valid;

    int n_checks;
    int n_pass;

    logic [W:0] exp_q[$];

    sklansky_adder_32_if #(.WIDTH(W)) bus ();

    sklansky_adder_32 #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain 33-bit unsigned addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Drive one operand set at the falling edge; it is captured at the next rising edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        drv_valid = 1'b1;
        exp_q.push_back(ref_add(a, b, cin));
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        drv_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check({name, "_instant"}, {bus.cout, bus.sum}, '0);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            check({name, "_hold"}, {bus.cout, bus.sum}, '0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every edge that captured a driven vector yields one result.
    initial begin
        forever begin
            @(posedge clk);
            if (drv_valid && !rst) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got %h expected none", {bus.cout, bus.sum});
                end else begin
                    check("result", {bus.cout, bus.sum}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        drv_valid = 1'b0;
        rst       = 1'b0;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'h0000_0001;
        bus.cin   = 1'b0;

        // First edge loads cout = 1, so the asynchronous clear is visible.
        @(posedge clk);
        #1;
        check("preload", {bus.cout, bus.sum}, {1'b1, 32'h0000_0000});
        #1;
        rst = 1'b1;
        #1;
        check("reset_instant", {bus.cout, bus.sum}, '0);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {bus.cout, bus.sum}, '0);
        end
        @(negedge clk);
        rst = 1'b0;

        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        drive(32'h0000_0000, 32'h0000_0000, 1'b0);
        drive(32'h0000_0000, 32'h0000_0000, 1'b1);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);

        for (int v = 0; v < 10000; v++) begin
            if (v == 5000) reset_pulse("mid_reset");
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        drv_valid = 1'b0;
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
